// File: rtl/riscv_pkg.sv
// Shared tiny-riscv types: load funct3 encodings, load queue entry and
// a register-number decode helper.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } ld_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/load_fmt.sv
// Load data formatter: selects the addressed byte/half lane of a word-aligned
// read and sign- or zero-extends it according to funct3.
module load_fmt
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [31:0] shifted_s;

  // Lane select, then extend; misaligned halves/words use the shifted value as-is
  always_comb begin
    shifted_s = mem_rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   data = shifted_s;
      F3_LBU:  data = {24'd0, shifted_s[7:0]};
      F3_LHU:  data = {16'd0, shifted_s[15:0]};
      default: data = shifted_s;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges execute results with in-order load responses, drives
// the register file write port and exports a pending-destination mask.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_we,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        ld_issue,
  output logic        ld_issue_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] pend_mask
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = $clog2(LD_DEPTH + 1);

  ld_entry_t           q_r [LD_DEPTH];
  logic [LD_DEPTH-1:0] vld_r;
  logic [PW-1:0]       wptr_r;
  logic [PW-1:0]       rptr_r;
  logic [CW-1:0]       cnt_r;

  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  ld_entry_t           head_s;
  logic [31:0]         fmt_s;
  logic [31:0]         mask_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(LD_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Queue status and handshakes; a refused issue is simply not pushed
  always_comb begin
    full_s         = (cnt_r == CW'(LD_DEPTH));
    empty_s        = (cnt_r == {CW{1'b0}});
    push_s         = ld_issue && !full_s;
    pop_s          = mem_rvalid && !empty_s;
    head_s         = q_r[rptr_r];
    ld_issue_ready = !full_s;
    ex_ready       = !pop_s;
  end

  // Queue payload storage, written on push only
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_r[wptr_r] <= '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};
    end
  end

  // Queue pointers, occupancy count and per-entry valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      vld_r  <= {LD_DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        vld_r[wptr_r] <= 1'b1;
        wptr_r        <= next_ptr(wptr_r);
      end
      if (pop_s) begin
        vld_r[rptr_r] <= 1'b0;
        rptr_r        <= next_ptr(rptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  load_fmt u_load_fmt (
    .mem_rdata (mem_rdata),
    .funct3    (head_s.funct3),
    .addr_lo   (head_s.addr_lo),
    .data      (fmt_s)
  );

  // Register file write port; load responses win over execute results
  always_ff @(posedge clk) begin
    if (rst) begin
      we      <= 1'b0;
      rd_addr <= 5'd0;
      rd_data <= 32'd0;
    end else if (pop_s) begin
      we      <= (head_s.rd != 5'd0);
      rd_addr <= head_s.rd;
      rd_data <= fmt_s;
    end else if (ex_valid) begin
      we      <= ex_we && (ex_rd != 5'd0);
      rd_addr <= ex_rd;
      rd_data <= ex_data;
    end else begin
      we      <= 1'b0;
    end
  end

  // Pending mask includes the write on the port, not yet visible in the regfile
  always_comb begin
    mask_s = 32'd0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      mask_s = mask_s | (vld_r[i] ? rd_onehot(q_r[i].rd) : 32'd0);
    end
    mask_s    = mask_s | (we ? rd_onehot(rd_addr) : 32'd0);
    mask_s[0] = 1'b0;
    pend_mask = mask_s;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a transaction-level model (queue of loads, expected write port).
module tb_wb_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_we, ld_issue, mem_rvalid;
  logic [4:0]  ex_rd, ld_rd;
  logic [31:0] ex_data, mem_rdata;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ex_ready, ld_issue_ready, we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, pend_mask;

  wb_stage #(.LD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we),
    .ex_rd(ex_rd), .ex_data(ex_data), .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready),
    .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ment_t;

  ment_t       mq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        allow_viol;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [31:0] w, b, h;
    w = rdata >> (8 * lo);
    b = w % 32'd256;
    h = w % 32'd65536;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] m;
    m = 32'd0;
    foreach (mq[i]) m = m | (32'd1 << mq[i].rd);
    if (m_we) m = m | (32'd1 << m_addr);
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic idle();
    rst = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
    ld_issue = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'd0; ld_addr_lo = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  // Advance model by one cycle using current inputs, then clock the DUT
  task automatic tick();
    logic  pop, push;
    ment_t e;
    pop  = mem_rvalid && (mq.size() > 0);
    push = ld_issue && (mq.size() < DEPTH);
    if (!rst && mem_rvalid && mq.size() == 0 && !allow_viol) begin
      n_fail++;
      $display("FAIL protocol: mem_rvalid with empty queue at %0t (got 1 required 0)", $time);
    end
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    end else begin
      if (pop) begin
        e = mq.pop_front();
        m_we = (e.rd != 5'd0); m_addr = e.rd; m_data = model_load(mem_rdata, e.f3, e.lo);
      end else if (ex_valid) begin
        m_we = ex_we && (ex_rd != 5'd0); m_addr = ex_rd; m_data = ex_data;
      end else begin
        m_we = 1'b0;
      end
      if (push) mq.push_back('{ld_rd, ld_funct3, ld_addr_lo});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); idle(); #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", we); end
    n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", rd_addr); end
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    n_checks++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pend got=%h exp=0", pend_mask); end
    n_checks++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ldrdy got=%b exp=1", ld_issue_ready); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_exrdy got=%b exp=1", ex_ready); end
  endtask

  task automatic test_exec();
    idle(); ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 5'd5; ex_data = 32'h1234_5678; #1;
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL exec_ready got=%b exp=1", ex_ready); end
    tick(); idle();
    n_checks++; if ({we, rd_addr} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL exec_port got=%b/%0d exp=1/5", we, rd_addr); end
    n_checks++; if (rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL exec_data got=%h exp=12345678", rd_data); end
    n_checks++; if (pend_mask !== 32'h20) begin n_fail++; $display("FAIL exec_pend got=%h exp=20", pend_mask); end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL exec_we_off got=%b exp=0", we); end
    n_checks++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL exec_pend_off got=%h exp=0", pend_mask); end
    n_checks++; if (rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL exec_hold got=%h exp=12345678", rd_data); end
  endtask

  task automatic test_load_fmt();
    logic [2:0]  f3 [3] = '{3'd0, 3'd4, 3'd5};
    logic [1:0]  lo [3] = '{2'd3, 2'd3, 2'd2};
    logic [31:0] rdv[3] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'hBEEF_0000};
    logic [31:0] exv[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF};
    for (int k = 0; k < 3; k++) begin
      idle(); ld_issue = 1'b1; ld_rd = 5'd7; ld_funct3 = f3[k]; ld_addr_lo = lo[k]; tick();
      idle();
      n_checks++; if (pend_mask !== 32'h80) begin n_fail++; $display("FAIL fmt_pend k=%0d got=%h exp=80", k, pend_mask); end
      mem_rvalid = 1'b1; mem_rdata = rdv[k]; tick(); idle();
      n_checks++; if ({we, rd_addr} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL fmt_port k=%0d got=%b/%0d exp=1/7", k, we, rd_addr); end
      n_checks++; if (rd_data !== exv[k]) begin n_fail++; $display("FAIL fmt_data k=%0d got=%h exp=%h", k, rd_data, exv[k]); end
      tick();
    end
  endtask

  task automatic test_queue_full();
    idle(); ld_issue = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'd2; tick();
    ld_rd = 5'd4; tick();
    ld_rd = 5'd9; #1;
    n_checks++; if (ld_issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", ld_issue_ready); end
    n_checks++; if (pend_mask !== 32'h18) begin n_fail++; $display("FAIL full_pend0 got=%h exp=18", pend_mask); end
    tick();
    // issue while full together with a response must still be refused
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033; tick();
    ld_issue = 1'b0;
    n_checks++; if ({we, rd_addr, rd_data} !== {1'b1, 5'd3, 32'h33}) begin n_fail++; $display("FAIL full_wr3 got=%b/%0d/%h exp=1/3/33", we, rd_addr, rd_data); end
    n_checks++; if (pend_mask !== 32'h18) begin n_fail++; $display("FAIL full_pend1 got=%h exp=18", pend_mask); end
    mem_rdata = 32'h0000_0044; tick(); idle();
    n_checks++; if ({we, rd_addr, rd_data} !== {1'b1, 5'd4, 32'h44}) begin n_fail++; $display("FAIL full_wr4 got=%b/%0d/%h exp=1/4/44", we, rd_addr, rd_data); end
    n_checks++; if (pend_mask !== 32'h10) begin n_fail++; $display("FAIL full_pend2 got=%h exp=10", pend_mask); end
    tick();
    n_checks++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL full_pend3 got=%h exp=0", pend_mask); end
    n_checks++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_drained got=%b exp=1", ld_issue_ready); end
  endtask

  task automatic test_arbitration();
    idle(); ld_issue = 1'b1; ld_rd = 5'd2; ld_funct3 = 3'd2; tick();
    idle(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 5'd6; ex_data = 32'h0000_0606; #1;
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL arb_exrdy got=%b exp=0", ex_ready); end
    tick(); mem_rvalid = 1'b0;
    n_checks++; if ({rd_addr, rd_data} !== {5'd2, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL arb_load got=%0d/%h exp=2/cafef00d", rd_addr, rd_data); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL arb_exrdy2 got=%b exp=1", ex_ready); end
    tick(); idle();
    n_checks++; if ({we, rd_addr, rd_data} !== {1'b1, 5'd6, 32'h606}) begin n_fail++; $display("FAIL arb_exec got=%b/%0d/%h exp=1/6/606", we, rd_addr, rd_data); end
    tick();
  endtask

  task automatic test_rd_zero();
    idle(); ld_issue = 1'b1; ld_rd = 5'd0; tick(); tick();
    idle(); #1;
    n_checks++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL rd0_pend got=%h exp=0", pend_mask); end
    n_checks++; if (ld_issue_ready !== 1'b0) begin n_fail++; $display("FAIL rd0_full got=%b exp=0", ld_issue_ready); end
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; tick(); tick(); idle();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rd0_ldwe got=%b exp=0", we); end
    n_checks++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_popped got=%b exp=1", ld_issue_ready); end
    ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 5'd0; ex_data = 32'h5; tick(); idle();
    n_checks++; if ({we, pend_mask} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL rd0_ex got=%b/%h exp=0/0", we, pend_mask); end
  endtask

  task automatic test_reset_flush();
    idle(); ld_issue = 1'b1; ld_rd = 5'd10; tick();
    ld_rd = 5'd11; tick();
    idle(); rst = 1'b1; tick(); idle();
    n_checks++; if ({we, pend_mask} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL flush_state got=%b/%h exp=0/0", we, pend_mask); end
    n_checks++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", ld_issue_ready); end
    allow_viol = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; #1;
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL flush_exrdy got=%b exp=1", ex_ready); end
    tick(); idle(); allow_viol = 1'b0;
    n_checks++; if ({we, rd_data, pend_mask} !== {1'b0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL flush_nowrite got=%b/%h/%h exp=0/0/0", we, rd_data, pend_mask); end
  endtask

  task automatic test_random();
    logic exp_exr, exp_lir;
    for (int c = 0; c < 600; c++) begin
      idle();
      rst        = ($urandom_range(0, 59) == 0);
      ex_valid   = $urandom_range(0, 1) == 1;
      ex_we      = $urandom_range(0, 3) != 0;
      ex_rd      = 5'($urandom_range(0, 7));
      ex_data    = $urandom;
      ld_issue   = $urandom_range(0, 1) == 1;
      ld_rd      = 5'($urandom_range(0, 7));
      ld_funct3  = 3'($urandom_range(0, 7));
      ld_addr_lo = 2'($urandom_range(0, 3));
      mem_rvalid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      exp_exr = !(mem_rvalid && mq.size() > 0);
      exp_lir = (mq.size() < DEPTH);
      #1;
      n_checks++; if (ex_ready !== exp_exr) begin n_fail++; $display("FAIL rnd_exrdy c=%0d got=%b exp=%b", c, ex_ready, exp_exr); end
      n_checks++; if (ld_issue_ready !== exp_lir) begin n_fail++; $display("FAIL rnd_ldrdy c=%0d got=%b exp=%b", c, ld_issue_ready, exp_lir); end
      tick();
      n_checks++; if (we !== m_we) begin n_fail++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, we, m_we); end
      n_checks++; if (rd_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, rd_addr, m_addr); end
      n_checks++; if (rd_data !== m_data) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, rd_data, m_data); end
      n_checks++; if (pend_mask !== model_pend()) begin n_fail++; $display("FAIL rnd_pend c=%0d got=%h exp=%h", c, pend_mask, model_pend()); end
    end
  endtask

  initial begin
    allow_viol = 1'b0;
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    idle();
    test_reset();
    test_exec();
    test_load_fmt();
    test_queue_full();
    test_arbitration();
    test_rd_zero();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for the tiny-riscv core. It merges single-cycle execute results with in-order load responses from data memory and formats loads by byte lane and sign. It drives the register file write port (`we`, `rd_addr`, `rd_data`) from registered outputs. It tracks outstanding loads in a small in-order queue and exports a pending-destination mask so decode can stall on read-after-write hazards.

## Interface
Parameters:
- `LD_DEPTH`, default 2: maximum number of outstanding loads (queue entries), ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: execute result present.
- `ex_ready` out 1: execute result accepted this cycle.
- `ex_we` in 1: execute result writes a register.
- `ex_rd` in 5: execute destination register.
- `ex_data` in 32: execute result.
- `ld_issue` in 1: a load is being issued to memory this cycle.
- `ld_issue_ready` out 1: load queue can take an entry.
- `ld_rd` in 5: load destination register.
- `ld_funct3` in 3: load type.
- `ld_addr_lo` in 2: byte address bits [1:0].
- `mem_rvalid` in 1: load data returned, in issue order; cannot be stalled.
- `mem_rdata` in 32: word-aligned load data.
- `we` out 1: register file write enable.
- `rd_addr` out 5: register file write address.
- `rd_data` out 32: register file write data.
- `pend_mask` out 32: bit n set means xn has an unwritten pending result; bit 0 is always 0.

## Operation
- Load queue: FIFO of {rd, funct3, addr_lo}, `LD_DEPTH` entries. Push on `ld_issue && ld_issue_ready`. Pop on `mem_rvalid` when the queue is non-empty.
- `ld_issue_ready = !full`. Issue while full is refused even if `mem_rvalid` is high that cycle.
- `mem_rvalid` with an empty queue is a protocol violation. It is ignored (no write, no state change) and flagged by a bench assertion.
- Load format: shift `mem_rdata` right by `addr_lo*8`, then:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other encodings: treated as LW.
- Misaligned LH/LW addresses are not checked. The shifted value is used as-is.
- Arbitration: a load response has priority. `ex_ready = !(mem_rvalid && !empty)`. Execute holds its result while not ready.
- Write generation, registered each cycle:
  - Load pop: `we` = (entry rd != 0), `rd_addr` = entry rd, `rd_data` = formatted data.
  - Otherwise, on execute accept: `we` = `ex_we && ex_rd != 0`, `rd_addr` = `ex_rd`, `rd_data` = `ex_data`.
  - Otherwise: `we` = 0. `rd_addr` and `rd_data` hold their values.
- `pend_mask` (combinational) = OR of decoded rd over all valid queue entries, OR (`we` ? decoded `rd_addr` : 0), with bit 0 cleared. This covers the cycle in which the write is on the port but not yet visible in the register file.

## Timing
- Reset: queue empty; `we`=0, `rd_addr`=0, `rd_data`=0; therefore `pend_mask`=0, `ld_issue_ready`=1, `ex_ready`=1.
- Reset mid-operation flushes all pending loads. Responses arriving afterwards hit an empty queue and are ignored.
- Latency:
  - Execute accept in cycle N gives `we`=1 in N+1, and the value is readable from the register file in N+2.
  - `mem_rvalid` in cycle N gives `we` in N+1.
- `pend_mask`:
  - A bit for a load rd sets in the cycle after issue.
  - It stays set through the response cycle and the `we` cycle.
  - It clears in the cycle after `we`.
- Simultaneous push and pop when not full: both happen, and occupancy is unchanged.
- Two queued loads to the same rd: the bit stays set until both have written.
- Pointers wrap modulo `LD_DEPTH`. Full/empty are tracked with a count, so non-power-of-two depths are legal.

## Structure
- Shared package `riscv_pkg`: load funct3 constants (LB, LH, LW, LBU, LHU) and the `ld_entry_t` struct {rd, funct3, addr_lo}.
- One sub-module, `load_fmt`: combinational shift and extend from (`mem_rdata`, `funct3`, `addr_lo`) to 32-bit data.
- The queue is written inline.

## Test plan
- Reset, then execute result rd=5, data=0x1234_5678: `we`=1, `rd_addr`=5, `rd_data`=0x12345678 the next cycle; `pend_mask` bit 5 is set only in that cycle.
- LB at addr_lo=3, `mem_rdata`=0x80FF_FFFF, rd=7: `rd_data`=0xFFFF_FF80. LBU at the same address gives 0x0000_0080. LHU at addr_lo=2 with 0xBEEF_0000 gives 0x0000_BEEF.
- Issue two loads (rd=3, rd=4), then `ld_issue_ready`=0. Third issue is refused. Responses write x3 then x4 in order. `pend_mask` goes 0x18 → 0x18 → 0x10 → 0.
- `mem_rvalid` and `ex_valid` in the same cycle: load writes first and `ex_ready`=0. Execute data is written the following cycle.
- Load and execute with rd=0: no `we`, and `pend_mask` stays 0. Queue entry still pops.
- Two loads outstanding, assert `rst`: queue empty, `we`=0, `pend_mask`=0. A later `mem_rvalid` produces no write.
